// File: rtl/regfile_param.sv
// LEGv8 register file: 2 registered read ports, 1 write port, hardwired-zero entry, self-clearing after reset/clear_req.
// Latency: reads 1 cycle; writes visible next cycle; REGFILE_BYPASS_EN selects write-first forwarding on same-edge hits.
// Backpressure: none; ready low while the clear sequencer runs (DEPTH cycles), inputs ignored meanwhile.
module regfile_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              ready
);

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clear_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_nxt1, rd_nxt2;
  logic              wr_act;

  // A clear request on the same edge discards the write presented with it.
  assign wr_act = (state == RUN) && !clear_req && wr_en && (wr_addr != ZERO_A);
  assign ready  = (state == RUN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      clear_ptr <= '0;
    end else begin
      state     <= state_nxt;
      clear_ptr <= (state == CLEAR) ? clear_ptr + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clear_ptr == LAST_A) state_nxt = RUN;
      RUN:     if (clear_req) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // Storage has no reset; the clear sequencer defines its contents.
  always_ff @(posedge clock) begin
    if (state == CLEAR)
      mem[clear_ptr] <= '0;
    else if (wr_act)
      mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_nxt1 = (rd_addr1 == ZERO_A) ? '0 : mem[rd_addr1];
    rd_nxt2 = (rd_addr2 == ZERO_A) ? '0 : mem[rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_act && (rd_addr1 == wr_addr)) rd_nxt1 = wr_data;
    if (wr_act && (rd_addr2 == wr_addr)) rd_nxt2 = wr_data;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else if (state == RUN) begin
      rd_data1 <= rd_nxt1;
      rd_data2 <= rd_nxt2;
    end else begin
      rd_data1 <= '0;
      rd_data2 <= '0;
    end
  end

endmodule
